// File: rtl/alu_ctrl_pkg.sv
// Opcode encodings, decode helpers and FSM states shared by the ALU issue controller.
// Latency: none (types and constants only); backpressure: not applicable.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD       = 4'b0000;
    localparam logic [3:0] OP_SUB       = 4'b0001;
    localparam logic [3:0] OP_MUL       = 4'b0010;
    localparam logic [3:0] MUL_MASK     = 4'b1110;
    localparam logic [3:0] LOAD_MASK    = 4'b1000;
    localparam logic [3:0] LOAD_VAL     = 4'b1000;
    localparam logic [3:0] ILLEGAL_MASK = 4'b1100;
    localparam logic [3:0] ILLEGAL_VAL  = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op & LOAD_MASK) == LOAD_VAL;
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op & ILLEGAL_MASK) == ILLEGAL_VAL;
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op & MUL_MASK) == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_issue_controller_if.sv
// Instruction, ALU-side and result handshake bundle of the ALU issue controller.
// Latency: wires only; backpressure: instr_valid/instr_ready and res_valid/res_ready.
interface alu_issue_if #(parameter int AW = 3);

    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    instr_opcode;
    logic [AW-1:0] instr_rd;
    logic [AW-1:0] instr_rs1;
    logic [AW-1:0] instr_rs2;
    logic [7:0]    instr_imm;

    logic [7:0]    alu_A;
    logic [7:0]    alu_B;
    logic [3:0]    alu_opcode;
    logic [7:0]    alu_Y;
    logic          alu_carry_out;

    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_data;
    logic [AW-1:0] res_rd;
    logic          res_carry;
    logic          res_err;

    // Controller side
    modport slave (
        input  instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2, instr_imm,
        input  alu_Y, alu_carry_out, res_ready,
        output instr_ready, alu_A, alu_B, alu_opcode,
        output res_valid, res_data, res_rd, res_carry, res_err
    );

    // Instruction source, arithmetic unit and result consumer side
    modport master (
        output instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2, instr_imm,
        output alu_Y, alu_carry_out, res_ready,
        input  instr_ready, alu_A, alu_B, alu_opcode,
        input  res_valid, res_data, res_rd, res_carry, res_err
    );

endinterface

// File: rtl/alu_regfile.sv
// NREGS x 8 register file: two combinational read ports, one synchronous write port.
// Latency: read 0 cycles, write visible after the edge; backpressure: none.
module alu_regfile #(
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic [7:0]    rdata_a_o,
    output logic [7:0]    rdata_b_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i
);

    logic [7:0] mem_q [NREGS];

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_issue_controller.sv
// Issues one instruction at a time to an external arithmetic unit and writes the result back.
// Latency: accept N -> result N+2 (one per 3 cycles max); backpressure: RESP holds until res_ready.
module alu_issue_controller
    import alu_ctrl_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave io
);

    localparam int AW = $clog2(NREGS);

    state_e        state_q;
    logic [3:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [7:0]    imm_q;
    logic [7:0]    alu_a_q;
    logic [7:0]    alu_b_q;
    logic          carry_q;

    logic          res_vld_q;
    logic [7:0]    res_data_q;
    logic [AW-1:0] res_rd_q;
    logic          res_carry_q;
    logic          res_err_q;

    logic [7:0]    rdata_a;
    logic [7:0]    rdata_b;
    logic          wr_en_d;
    logic [7:0]    wr_dat_d;
    logic          carry_d;

    alu_regfile #(.NREGS(NREGS)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a_i (io.instr_rs1),
        .raddr_b_i (io.instr_rs2),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b),
        .we_i      (wr_en_d),
        .waddr_i   (rd_q),
        .wdata_i   (wr_dat_d)
    );

    // LOAD and ILLEGAL leave the carry flag alone; MUL clears it whatever the ALU says.
    always_comb begin
        wr_en_d  = (state_q == EXEC) && !is_illegal(op_q);
        wr_dat_d = is_load(op_q) ? imm_q : io.alu_Y;
        carry_d  = carry_q;
        if (!is_load(op_q) && !is_illegal(op_q)) begin
            carry_d = is_mul(op_q) ? 1'b0 : io.alu_carry_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 4'h0;
            rd_q        <= '0;
            imm_q       <= 8'h00;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            carry_q     <= 1'b0;
            res_vld_q   <= 1'b0;
            res_data_q  <= 8'h00;
            res_rd_q    <= '0;
            res_carry_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.instr_valid) begin
                        op_q    <= io.instr_opcode;
                        rd_q    <= io.instr_rd;
                        imm_q   <= io.instr_imm;
                        alu_a_q <= rdata_a;
                        alu_b_q <= rdata_b;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_q  <= is_illegal(op_q) ? 8'h00 : wr_dat_d;
                    res_rd_q    <= rd_q;
                    res_carry_q <= carry_d;
                    res_err_q   <= is_illegal(op_q);
                    carry_q     <= carry_d;
                    res_vld_q   <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (io.res_ready) begin
                        res_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    res_vld_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Ready is gated by rst_n so nothing is taken while reset is held.
    assign io.instr_ready = rst_n && (state_q == IDLE);
    assign io.alu_A       = alu_a_q;
    assign io.alu_B       = alu_b_q;
    assign io.alu_opcode  = op_q;
    assign io.res_valid   = res_vld_q;
    assign io.res_data    = res_data_q;
    assign io.res_rd      = res_rd_q;
    assign io.res_carry   = res_carry_q;
    assign io.res_err     = res_err_q;

endmodule

// File: tb/tb_alu_issue_controller.sv
// Bench for alu_issue_controller with a behavioural arithmetic unit beside it.
// Directed test-plan steps followed by randomized instructions against a reference model.
module tb_alu_issue_controller;

    localparam int NREGS = 8;
    localparam int AW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_issue_if #(.AW(AW)) bus ();

    alu_issue_controller #(.NREGS(NREGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    // Arithmetic unit stand-in; non-ALU opcodes return junk so misuse of Y/carry shows up.
    always_comb begin
        bus.alu_Y         = bus.alu_A ^ bus.alu_B ^ 8'h5A;
        bus.alu_carry_out = 1'b1;
        case (bus.alu_opcode)
            4'b0000: {bus.alu_carry_out, bus.alu_Y} = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
            4'b0001: begin
                bus.alu_Y         = bus.alu_A - bus.alu_B;
                bus.alu_carry_out = (bus.alu_A >= bus.alu_B);
            end
            4'b0010, 4'b0011: begin
                bus.alu_Y         = 8'(bus.alu_A[7:4] * bus.alu_B[7:4]);
                bus.alu_carry_out = 1'b1;
            end
            default: ;
        endcase
    end

    int n_asserts = 0;
    int n_fail    = 0;
    int mregs [NREGS];
    int mcarry;

    task automatic chk(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: instruction semantics in plain integer arithmetic.
    task automatic model(input int op, input int rd, input int rs1, input int rs2, input int imm,
                         output int d, output int c, output int e);
        int a;
        int b;
        a = mregs[rs1];
        b = mregs[rs2];
        e = 0;
        c = mcarry;
        if (op >= 8) begin
            d = imm;
            mregs[rd] = imm;
        end else if (op >= 4) begin
            d = 0;
            e = 1;
        end else begin
            if (op == 0) begin
                d = (a + b) % 256;
                c = (a + b > 255) ? 1 : 0;
            end else if (op == 1) begin
                d = (a - b + 256) % 256;
                c = (a >= b) ? 1 : 0;
            end else begin
                d = (a / 16) * (b / 16);
                c = 0;
            end
            mregs[rd] = d;
            mcarry = c;
        end
    endtask

    // Entered and left just after a falling edge.
    task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int imm,
                         input int stall);
        int ea, eb, ed, ec, ee, cyc;
        ea = mregs[rs1];
        eb = mregs[rs2];
        model(op, rd, rs1, rs2, imm, ed, ec, ee);
        cyc = 0;
        while (!bus.instr_ready && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("instr_ready_idle", int'(bus.instr_ready), 1);
        bus.instr_opcode = 4'(op);
        bus.instr_rd     = AW'(rd);
        bus.instr_rs1    = AW'(rs1);
        bus.instr_rs2    = AW'(rs2);
        bus.instr_imm    = 8'(imm);
        bus.instr_valid  = 1'b1;
        bus.res_ready    = (stall == 0);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("alu_A", int'(bus.alu_A), ea);
        chk("alu_B", int'(bus.alu_B), eb);
        chk("alu_opcode", int'(bus.alu_opcode), op);
        chk("res_valid_exec", int'(bus.res_valid), 0);
        chk("instr_ready_exec", int'(bus.instr_ready), 0);
        @(negedge clk);
        chk("res_valid_resp", int'(bus.res_valid), 1);
        chk("res_data", int'(bus.res_data), ed);
        chk("res_rd", int'(bus.res_rd), rd);
        chk("res_carry", int'(bus.res_carry), ec);
        chk("res_err", int'(bus.res_err), ee);
        chk("instr_ready_resp", int'(bus.instr_ready), 0);
        for (int s = 0; s < stall; s++) begin
            bus.instr_opcode = 4'($urandom_range(0, 15));
            bus.instr_rd     = AW'($urandom_range(0, NREGS - 1));
            bus.instr_rs1    = AW'($urandom_range(0, NREGS - 1));
            bus.instr_imm    = 8'($urandom_range(0, 255));
            bus.instr_valid  = 1'b1;
            @(negedge clk);
            chk("stall_res_valid", int'(bus.res_valid), 1);
            chk("stall_res_data", int'(bus.res_data), ed);
            chk("stall_res_rd", int'(bus.res_rd), rd);
            chk("stall_res_carry", int'(bus.res_carry), ec);
            chk("stall_res_err", int'(bus.res_err), ee);
            chk("stall_instr_ready", int'(bus.instr_ready), 0);
        end
        bus.instr_valid = 1'b0;
        bus.res_ready   = 1'b1;
        @(negedge clk);
        chk("res_valid_drop", int'(bus.res_valid), 0);
        chk("instr_ready_back", int'(bus.instr_ready), 1);
    endtask

    initial begin
        bus.instr_valid  = 1'b0;
        bus.instr_opcode = 4'h0;
        bus.instr_rd     = '0;
        bus.instr_rs1    = '0;
        bus.instr_rs2    = '0;
        bus.instr_imm    = 8'h00;
        bus.res_ready    = 1'b1;
        for (int i = 0; i < NREGS; i++) mregs[i] = 0;
        mcarry = 0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_instr_ready", int'(bus.instr_ready), 0);
        chk("rst_alu_A", int'(bus.alu_A), 0);
        chk("rst_alu_B", int'(bus.alu_B), 0);
        chk("rst_alu_opcode", int'(bus.alu_opcode), 0);
        chk("rst_res_data", int'(bus.res_data), 0);
        chk("rst_res_rd", int'(bus.res_rd), 0);
        chk("rst_res_carry", int'(bus.res_carry), 0);
        chk("rst_res_err", int'(bus.res_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LOAD / ADD without carry
        issue(8, 1, 0, 0, 'h3C, 0);
        issue(8, 2, 0, 0, 'h05, 0);
        issue(0, 3, 1, 2, 0, 0);
        // ADD with carry, SUB with borrow
        issue(8, 1, 0, 0, 'hF0, 0);
        issue(8, 2, 0, 0, 'h20, 0);
        issue(0, 4, 1, 2, 0, 0);
        issue(1, 5, 2, 1, 0, 0);
        // MUL, both encodings
        issue(8, 1, 0, 0, 'hA0, 0);
        issue(12, 2, 0, 0, 'hC0, 0);
        issue(2, 6, 1, 2, 0, 0);
        issue(3, 6, 1, 2, 0, 0);
        // Set the carry, then ILLEGAL to r1 must not write nor touch the flag
        issue(0, 3, 1, 2, 0, 0);
        issue(4, 1, 2, 2, 'h77, 0);
        issue(0, 0, 1, 1, 0, 0);
        issue(9, 7, 0, 0, 'h11, 0);
        // rd equal to source, rs1 == rs2
        issue(0, 7, 7, 7, 0, 0);
        // Result backpressure
        issue(0, 2, 1, 2, 0, 5);

        // Reset during EXEC of ADD r7
        bus.instr_opcode = 4'h0;
        bus.instr_rd     = AW'(7);
        bus.instr_rs1    = AW'(1);
        bus.instr_rs2    = AW'(2);
        bus.instr_valid  = 1'b1;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("pre_rst_exec_ready", int'(bus.instr_ready), 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_res_valid", int'(bus.res_valid), 0);
        chk("midrst_instr_ready", int'(bus.instr_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_instr_ready", int'(bus.instr_ready), 1);
        for (int i = 0; i < NREGS; i++) mregs[i] = 0;
        mcarry = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_no_result", int'(bus.res_valid), 0);
        end
        issue(0, 0, 7, 7, 0, 0);

        // Randomized instructions
        for (int k = 0; k < 60; k++) begin
            int op, rd, rs1, rs2, imm, st;
            op  = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
            rd  = $urandom_range(0, NREGS - 1);
            rs1 = $urandom_range(0, NREGS - 1);
            rs2 = $urandom_range(0, NREGS - 1);
            imm = $urandom_range(0, 255);
            st  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            issue(op, rd, rs1, rs2, imm, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
